// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the HDMI I2C configuration sequencer.
package i2c_cfg_pkg;

  // Sequencer states
  typedef enum logic [3:0] {
    PWRUP,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    CHECK,
    GAP,
    DONE,
    FAIL
  } state_t;

  localparam logic [7:0] DEFAULT_SLAVE_ADDR = 8'h72;

  // I2C_DATA layout: {addr, reg, val}
  localparam int unsigned DATA_W   = 24;
  localparam int unsigned ADDR_MSB = 23;
  localparam int unsigned ADDR_LSB = 16;
  localparam int unsigned REG_MSB  = 15;
  localparam int unsigned REG_LSB  = 8;
  localparam int unsigned VAL_MSB  = 7;
  localparam int unsigned VAL_LSB  = 0;

  // Shared cycle counter (power-up, gap and timeout never overlap)
  localparam int unsigned CNT_W = 20;

  // Saturating increment: the counter sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // True on the last cycle of a lim-cycle interval that started with cnt = 0
  function automatic logic count_reached(input logic [CNT_W-1:0] cnt,
                                         input logic [CNT_W-1:0] lim);
    return ({1'b0, cnt} + (CNT_W+1)'(1)) >= {1'b0, lim};
  endfunction

endpackage

// File: rtl/i2c_config_sequencer_if.sv
// Handshake/bus between the config sequencer and I2C_Controller.
interface i2c_config_sequencer_if;
  import i2c_cfg_pkg::*;

  logic [DATA_W-1:0] I2C_DATA;
  logic              GO;
  logic              I2C_END;
  logic              I2C_ACK;

  modport master (output I2C_DATA, output GO, input I2C_END, input I2C_ACK);
  modport slave  (input I2C_DATA, input GO, output I2C_END, output I2C_ACK);
endinterface

// File: rtl/hdmi_config_rom.sv
// HDMI transmitter init table: {reg, val} per entry, zero beyond DEPTH.
module hdmi_config_rom #(
  parameter int unsigned DEPTH = 32
) (
  input  logic [7:0]  addr,
  output logic [15:0] data_c
);

  // Table lookup; out-of-range entries read as zero
  always_comb begin
    data_c = 16'h0000;
    if (32'(addr) < DEPTH) begin
      case (addr)
        8'd0:    data_c = 16'h9803;
        8'd1:    data_c = 16'h0100;
        8'd2:    data_c = 16'h0218;
        8'd3:    data_c = 16'h0300;
        8'd4:    data_c = 16'h1470;
        8'd5:    data_c = 16'h1520;
        8'd6:    data_c = 16'h1630;
        8'd7:    data_c = 16'h1846;
        8'd8:    data_c = 16'h4080;
        8'd9:    data_c = 16'h4110;
        8'd10:   data_c = 16'h49A8;
        8'd11:   data_c = 16'h5510;
        8'd12:   data_c = 16'h5608;
        8'd13:   data_c = 16'h96F6;
        8'd14:   data_c = 16'h7307;
        8'd15:   data_c = 16'h761F;
        8'd16:   data_c = 16'h9803;
        8'd17:   data_c = 16'h9902;
        8'd18:   data_c = 16'h9AE0;
        8'd19:   data_c = 16'h9C30;
        8'd20:   data_c = 16'h9D61;
        8'd21:   data_c = 16'hA2A4;
        8'd22:   data_c = 16'hA3A4;
        8'd23:   data_c = 16'hA504;
        8'd24:   data_c = 16'hAB40;
        8'd25:   data_c = 16'hAF16;
        8'd26:   data_c = 16'hBA60;
        8'd27:   data_c = 16'hD1FF;
        8'd28:   data_c = 16'hDE10;
        8'd29:   data_c = 16'hE460;
        8'd30:   data_c = 16'hFA7D;
        8'd31:   data_c = 16'h0A01;
        default: data_c = 16'h0000;
      endcase
    end
  end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks the HDMI init table through I2C_Controller with ACK check and retry.
// Optional: define HPD_RECONFIG_EN to re-run the table on a hot-plug rising edge.
module i2c_config_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter logic [7:0]  SLAVE_ADDR     = DEFAULT_SLAVE_ADDR,
  parameter int unsigned LUT_SIZE       = 32,
  parameter int unsigned RETRY_MAX      = 3,
  parameter logic [19:0] POWERUP_CYCLES = 20'd1_000_000,
  parameter logic [15:0] GAP_CYCLES     = 16'd1000,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd500_000,
  localparam int unsigned IDX_W = (LUT_SIZE > 1) ? $clog2(LUT_SIZE) : 1
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  i2c_config_sequencer_if.master bus,
  input  logic                   HPD,
  output logic                   READY,
  output logic                   ERROR,
  output logic [IDX_W-1:0]       INDEX
);

  localparam int unsigned RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               fail_q, fail_d;
  logic               go_q, go_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               ready_q, ready_d;
  logic               error_q, error_d;
  logic [15:0]        rom_word_c;
  logic               hpd_rise_c;

  hdmi_config_rom #(.DEPTH(LUT_SIZE)) u_rom (
    .addr   (8'(index_q)),
    .data_c (rom_word_c)
  );

`ifdef HPD_RECONFIG_EN
  logic [2:0] hpd_sync_q;

  // Two-flop synchroniser plus one stage for edge detection
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) hpd_sync_q <= '0;
    else        hpd_sync_q <= {hpd_sync_q[1:0], HPD};
  end

  assign hpd_rise_c = hpd_sync_q[1] & ~hpd_sync_q[2];
`else
  logic hpd_unused;
  assign hpd_unused = HPD;
  assign hpd_rise_c = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= PWRUP;
      cnt_q   <= '0;
      retry_q <= '0;
      index_q <= '0;
      fail_q  <= 1'b0;
      go_q    <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      index_q <= index_d;
      fail_q  <= fail_d;
      go_q    <= go_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    index_d = index_q;
    fail_d  = fail_q;
    go_d    = go_q;
    data_d  = data_q;
    ready_d = ready_q;
    error_d = error_q;

    case (state_q)
      PWRUP: begin
        if (count_reached(cnt_q, CNT_W'(POWERUP_CYCLES))) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      LOAD: begin
        data_d[ADDR_MSB:ADDR_LSB] = SLAVE_ADDR;
        data_d[REG_MSB:REG_LSB]   = rom_word_c[15:8];
        data_d[VAL_MSB:VAL_LSB]   = rom_word_c[7:0];
        state_d                   = START;
      end

      START: begin
        go_d    = 1'b1;
        cnt_d   = '0;
        fail_d  = 1'b0;
        state_d = WAIT_BUSY;
      end

      // A stale END high does not count; the controller must go busy first
      WAIT_BUSY: begin
        if (!bus.I2C_END) begin
          cnt_d   = sat_inc(cnt_q);
          state_d = WAIT_DONE;
        end else if (count_reached(cnt_q, CNT_W'(TIMEOUT_CYCLES))) begin
          go_d    = 1'b0;
          fail_d  = 1'b1;
          state_d = CHECK;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      WAIT_DONE: begin
        if (bus.I2C_END) begin
          go_d    = 1'b0;
          fail_d  = bus.I2C_ACK;
          state_d = CHECK;
        end else if (count_reached(cnt_q, CNT_W'(TIMEOUT_CYCLES))) begin
          go_d    = 1'b0;
          fail_d  = 1'b1;
          state_d = CHECK;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      CHECK: begin
        cnt_d = '0;
        if (!fail_q) begin
          retry_d = '0;
          if (index_q == IDX_W'(LUT_SIZE - 1)) begin
            ready_d = 1'b1;
            state_d = DONE;
          end else begin
            index_d = index_q + IDX_W'(1);
            state_d = GAP;
          end
        end else if (retry_q < RETRY_W'(RETRY_MAX)) begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = GAP;
        end else begin
          error_d = 1'b1;
          state_d = FAIL;
        end
      end

      GAP: begin
        go_d = 1'b0;
        if (count_reached(cnt_q, CNT_W'(GAP_CYCLES))) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      DONE, FAIL: begin
        go_d = 1'b0;
        if (hpd_rise_c) begin
          ready_d = 1'b0;
          error_d = 1'b0;
          index_d = '0;
          retry_d = '0;
          cnt_d   = '0;
          state_d = GAP;
        end
      end

      default: begin
        go_d    = 1'b0;
        state_d = PWRUP;
      end
    endcase
  end

  assign bus.GO       = go_q;
  assign bus.I2C_DATA = data_q;
  assign READY        = ready_q;
  assign ERROR        = error_q;
  assign INDEX        = index_q;

endmodule
